// File: rtl/fft_frame_gen.sv
// Avalon-ST framing generator for an FFT sink port: emits valid/sop/eop and a sample index
// for FRAME_LEN-sample frames, with single, N-frame or continuous runs and an optional inter-frame gap.
module fft_frame_gen #(
    parameter int FRAME_LEN = 1024,
    parameter int GAP_LEN   = 0,
    parameter int CNT_W     = 16,
    parameter int NFR_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             stop,
    input  logic [NFR_W-1:0] num_frames,
    input  logic             sink_ready,
    output logic             sink_valid,
    output logic             sink_sop,
    output logic             sink_eop,
    output logic [CNT_W-1:0] sample_idx,
    output logic             busy,
    output logic             frame_done
);

    typedef enum logic [1:0] {IDLE, STREAM, GAP} state_t;

    localparam logic [CNT_W-1:0] IDX_LAST  = CNT_W'(FRAME_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic             FIRST_EOP = (FRAME_LEN == 1);

    state_t           state_q, state_d;
    logic             valid_q, valid_d;
    logic             sop_q, sop_d;
    logic             eop_q, eop_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [NFR_W-1:0] left_q, left_d;
    logic             cont_q, cont_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic             go_frame, go_idle;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        idx_d    = idx_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        left_d   = left_q;
        cont_d   = cont_q;
        gap_d    = gap_q;
        go_frame = 1'b0;
        go_idle  = 1'b0;
        // A stop seen on the same edge as the final beat still ends the run there.
        stop_d   = stop_q | (stop & (state_q != IDLE));

        case (state_q)
            IDLE: begin
                if (start) begin
                    go_frame = 1'b1;
                    left_d   = num_frames;
                    cont_d   = (num_frames == '0);
                end
            end
            STREAM: begin
                if (sink_ready) begin
                    if (eop_q) begin
                        done_d = 1'b1;
                        if (!cont_q) left_d = left_q - NFR_W'(1);
                        if ((!cont_q && left_q == NFR_W'(1)) || stop_d) begin
                            go_idle = 1'b1;
                        end else if (GAP_LEN > 0) begin
                            state_d = GAP;
                            valid_d = 1'b0;
                            sop_d   = 1'b0;
                            eop_d   = 1'b0;
                            idx_d   = '0;
                            gap_d   = '0;
                        end else begin
                            go_frame = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                        sop_d = 1'b0;
                        eop_d = ((idx_q + CNT_W'(1)) == IDX_LAST);
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (stop_d) go_idle = 1'b1;
                    else        go_frame = 1'b1;
                end else begin
                    gap_d = gap_q + CNT_W'(1);
                end
            end
            default: go_idle = 1'b1;
        endcase

        if (go_frame) begin
            state_d = STREAM;
            valid_d = 1'b1;
            sop_d   = 1'b1;
            eop_d   = FIRST_EOP;
            idx_d   = '0;
            busy_d  = 1'b1;
        end
        if (go_idle) begin
            state_d = IDLE;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            idx_d   = '0;
            busy_d  = 1'b0;
            stop_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            left_q  <= '0;
            cont_q  <= 1'b0;
            stop_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            left_q  <= left_d;
            cont_q  <= cont_d;
            stop_q  <= stop_d;
            gap_q   <= gap_d;
        end
    end

    assign sink_valid = valid_q;
    assign sink_sop   = sop_q;
    assign sink_eop   = eop_q;
    assign sample_idx = idx_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_fft_frame_gen.sv
// Bench for fft_frame_gen: three configurations (8/0, 8/3, 1/0); a negedge monitor records accepted
// beats and inter-frame gaps, and each scenario compares them against frames built from the framing rules.
module tb_fft_frame_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [2:0] start = '0, stop = '0, rdy = '0;
    logic [2:0][7:0] nf = '0;
    logic [2:0] vld, sop, eop, busy, fd;
    logic [2:0][15:0] idx;

    always #5 clk = ~clk;

    fft_frame_gen #(.FRAME_LEN(8), .GAP_LEN(0), .CNT_W(16), .NFR_W(8)) u_a (
        .clk(clk), .rst_n(rst_n), .start(start[0]), .stop(stop[0]), .num_frames(nf[0]),
        .sink_ready(rdy[0]), .sink_valid(vld[0]), .sink_sop(sop[0]), .sink_eop(eop[0]),
        .sample_idx(idx[0]), .busy(busy[0]), .frame_done(fd[0]));
    fft_frame_gen #(.FRAME_LEN(8), .GAP_LEN(3), .CNT_W(16), .NFR_W(8)) u_b (
        .clk(clk), .rst_n(rst_n), .start(start[1]), .stop(stop[1]), .num_frames(nf[1]),
        .sink_ready(rdy[1]), .sink_valid(vld[1]), .sink_sop(sop[1]), .sink_eop(eop[1]),
        .sample_idx(idx[1]), .busy(busy[1]), .frame_done(fd[1]));
    fft_frame_gen #(.FRAME_LEN(1), .GAP_LEN(0), .CNT_W(16), .NFR_W(8)) u_c (
        .clk(clk), .rst_n(rst_n), .start(start[2]), .stop(stop[2]), .num_frames(nf[2]),
        .sink_ready(rdy[2]), .sink_valid(vld[2]), .sink_sop(sop[2]), .sink_eop(eop[2]),
        .sample_idx(idx[2]), .busy(busy[2]), .frame_done(fd[2]));

    typedef struct { int idx; bit sop; bit eop; } beat_t;

    int checks = 0, errors = 0;
    int sel = 0;
    beat_t bq[$];
    int gapq[$];
    int stab_err, idx_err, fd_err, fd_cnt, cyc, eop_cyc;
    bit have_eop, prev_hold, fd_exp;
    logic pv, psop, peop;
    logic [15:0] pidx;

    // Monitor for the selected instance, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            prev_hold = 0; have_eop = 0; fd_exp = 0;
        end else begin
            cyc++;
            if (prev_hold && (vld[sel] !== pv || sop[sel] !== psop || eop[sel] !== peop || idx[sel] !== pidx))
                stab_err++;
            if (!vld[sel] && idx[sel] != 16'd0) idx_err++;
            if (fd[sel] !== fd_exp) fd_err++;
            if (fd[sel]) fd_cnt++;
            if (!busy[sel]) have_eop = 0;
            if (vld[sel] && sop[sel] && !prev_hold && have_eop) gapq.push_back(cyc - eop_cyc - 1);
            fd_exp = vld[sel] && rdy[sel] && eop[sel];
            if (vld[sel] && rdy[sel]) begin
                bq.push_back('{int'(idx[sel]), sop[sel], eop[sel]});
                if (eop[sel]) begin have_eop = 1; eop_cyc = cyc; end
            end
            prev_hold = vld[sel] && !rdy[sel];
            pv = vld[sel]; psop = sop[sel]; peop = eop[sel]; pidx = idx[sel];
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon(input int s);
        sel = s;
        bq.delete(); gapq.delete();
        stab_err = 0; idx_err = 0; fd_err = 0; fd_cnt = 0;
    endtask

    function automatic logic pick(int mode, int n);
        case (mode)
            0:       return 1'b1;
            1:       return (n % 4 == 0) || (n % 4 == 3);
            default: return ($urandom_range(0, 2) != 0);
        endcase
    endfunction

    task automatic run_until_idle(input int maxc, input int mode, output bit to);
        int n = 0;
        do begin
            rdy[sel] = pick(mode, n);
            tick();
            n++;
        end while (busy[sel] && n < maxc);
        to = busy[sel];
        tick();
    endtask

    // Reference: nfr frames of L beats, idx 0..L-1, sop on first, eop on last.
    function automatic int beats_bad(int L, int nfr);
        int bad = 0;
        if (bq.size() != L * nfr) return 1000 + bq.size();
        for (int k = 0; k < bq.size(); k++) begin
            int i = k % L;
            if (bq[k].idx != i || bq[k].sop != (i == 0) || bq[k].eop != (i == L - 1)) bad++;
        end
        return bad;
    endfunction

    function automatic int gaps_bad(int n, int g);
        int bad = 0;
        if (gapq.size() != n) return 1000 + gapq.size();
        foreach (gapq[k]) if (gapq[k] != g) bad++;
        return bad;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({vld[k], sop[k], eop[k], busy[k], fd[k]} !== 5'b0 || idx[k] !== 16'd0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: got v%b s%b e%b b%b d%b idx%0d, expected all 0",
                         k, vld[k], sop[k], eop[k], busy[k], fd[k], idx[k]);
            end
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        bit to; int bad;
        clear_mon(0);
        nf[0] = 8'd1; rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        checks++;
        if ({vld[0], sop[0], eop[0], busy[0]} !== 4'b1101 || idx[0] !== 16'd0) begin
            errors++;
            $display("FAIL single_first_beat: got v%b s%b e%b b%b idx%0d, expected v1 s1 e0 b1 idx0",
                     vld[0], sop[0], eop[0], busy[0], idx[0]);
        end
        run_until_idle(100, 0, to);
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout: busy still 1 after 100 cycles, expected 0"); end
        bad = beats_bad(8, 1);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL single_beats: got %0d bad, expected 0", bad); end
        checks++;
        if (fd_cnt != 1 || fd_err != 0) begin
            errors++; $display("FAIL single_frame_done: got %0d pulses (%0d mistimed), expected 1 (0)", fd_cnt, fd_err);
        end
        checks++;
        if (vld[0] !== 1'b0 || busy[0] !== 1'b0) begin
            errors++; $display("FAIL single_idle: got valid %b busy %b, expected 0 0", vld[0], busy[0]);
        end
    endtask

    task automatic test_backpressure();
        bit to; int bad;
        clear_mon(0);
        nf[0] = 8'd1; rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        run_until_idle(200, 1, to);
        bad = beats_bad(8, 1);
        checks++;
        if (to || bad != 0) begin errors++; $display("FAIL bp_beats: got %0d bad (timeout %b), expected 0", bad, to); end
        checks++;
        if (stab_err != 0 || idx_err != 0) begin
            errors++; $display("FAIL bp_stable: got %0d unstable, %0d idx-nonzero, expected 0 0", stab_err, idx_err);
        end
        checks++;
        if (fd_cnt != 1) begin errors++; $display("FAIL bp_frame_done: got %0d, expected 1", fd_cnt); end
    endtask

    task automatic test_random_frames();
        bit to; int bad; int n;
        n = $urandom_range(2, 4);
        clear_mon(0);
        nf[0] = 8'(n); start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        run_until_idle(500, 2, to);
        bad = beats_bad(8, n) + gaps_bad(n - 1, 0);
        checks++;
        if (to || bad != 0) begin errors++; $display("FAIL rand_frames: got %0d bad for %0d frames, expected 0", bad, n); end
        checks++;
        if (fd_cnt != n || fd_err != 0 || stab_err != 0) begin
            errors++; $display("FAIL rand_frame_done: got %0d pulses, %0d mistimed, %0d unstable, expected %0d 0 0",
                               fd_cnt, fd_err, stab_err, n);
        end
    endtask

    task automatic test_gap();
        bit to; int bad;
        clear_mon(1);
        nf[1] = 8'd2; start[1] = 1'b1; stop[1] = 1'b1;
        tick();
        start[1] = 1'b0; stop[1] = 1'b0;
        run_until_idle(500, 2, to);
        bad = beats_bad(8, 2);
        checks++;
        if (to || bad != 0) begin errors++; $display("FAIL gap_beats: got %0d bad, expected 0", bad); end
        bad = gaps_bad(1, 3);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL gap_length: got %0d bad gaps (n=%0d), expected 0", bad, gapq.size()); end
        checks++;
        if (fd_cnt != 2 || fd_err != 0 || idx_err != 0) begin
            errors++; $display("FAIL gap_frame_done: got %0d pulses, %0d mistimed, %0d idx, expected 2 0 0", fd_cnt, fd_err, idx_err);
        end
    endtask

    task automatic test_gap_stop();
        bit to; int n = 0; int bad;
        clear_mon(1);
        nf[1] = 8'd0; start[1] = 1'b1; rdy[1] = 1'b1;
        tick();
        start[1] = 1'b0;
        while (!(busy[1] && !vld[1]) && n < 50) begin tick(); n++; end
        stop[1] = 1'b1;
        tick();
        stop[1] = 1'b0;
        run_until_idle(100, 0, to);
        bad = beats_bad(8, 1) + gaps_bad(0, 0);
        checks++;
        if (to || n >= 50 || bad != 0 || fd_cnt != 1) begin
            errors++; $display("FAIL gap_stop: got %0d bad, %0d pulses, expected 0 bad 1 pulse", bad, fd_cnt);
        end
    endtask

    task automatic test_continuous_stop();
        bit to; int n = 0; int bad; int frames;
        clear_mon(0);
        nf[0] = 8'd0; rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (bq.size() < 12 && n < 100) begin tick(); n++; end
        frames = bq.size() / 8 + 1;
        stop[0] = 1'b1;
        tick();
        stop[0] = 1'b0;
        run_until_idle(100, 0, to);
        bad = beats_bad(8, frames);
        checks++;
        if (to || n >= 100 || bad != 0) begin errors++; $display("FAIL cont_stop_beats: got %0d bad, expected 0", bad); end
        bad = gaps_bad(frames - 1, 0);
        checks++;
        if (bad != 0) begin errors++; $display("FAIL cont_back_to_back: got %0d bad gaps, expected 0", bad); end
        checks++;
        if (fd_cnt != frames) begin errors++; $display("FAIL cont_frame_done: got %0d, expected %0d", fd_cnt, frames); end
    endtask

    task automatic test_frame_len1();
        bit to; int bad; int n;
        n = $urandom_range(2, 6);
        clear_mon(2);
        nf[2] = 8'(n); start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        nf[2] = 8'(n + 3); start[2] = 1'b1;
        tick();
        start[2] = 1'b0;
        run_until_idle(300, 2, to);
        bad = beats_bad(1, n) + gaps_bad(n - 1, 0);
        checks++;
        if (to || bad != 0) begin errors++; $display("FAIL len1_beats: got %0d bad for %0d frames, expected 0", bad, n); end
        checks++;
        if (fd_cnt != n || fd_err != 0 || stab_err != 0) begin
            errors++; $display("FAIL len1_frame_done: got %0d pulses, %0d mistimed, %0d unstable, expected %0d 0 0",
                               fd_cnt, fd_err, stab_err, n);
        end
    endtask

    task automatic test_reset_mid();
        bit to; int n = 0; int bad = 0;
        clear_mon(0);
        nf[0] = 8'd1; rdy[0] = 1'b1; start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        while (bq.size() < 4 && n < 50) begin tick(); n++; end
        checks++;
        if (idx[0] !== 16'd4) begin errors++; $display("FAIL rst_mid_pos: got idx %0d, expected 4", idx[0]); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({vld[0], sop[0], eop[0], busy[0], fd[0]} !== 5'b0 || idx[0] !== 16'd0) begin
            errors++; $display("FAIL rst_mid_async: got v%b e%b b%b idx%0d, expected all 0", vld[0], eop[0], busy[0], idx[0]);
        end
        tick();
        foreach (bq[k]) if (bq[k].eop) bad++;
        checks++;
        if (bq.size() != 4 || bad != 0) begin
            errors++; $display("FAIL rst_mid_no_eop: got %0d beats %0d eops, expected 4 0", bq.size(), bad);
        end
        @(negedge clk); rst_n = 1'b1;
        tick();
        clear_mon(0);
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        run_until_idle(100, 0, to);
        bad = beats_bad(8, 1);
        checks++;
        if (to || bad != 0 || fd_cnt != 1) begin
            errors++; $display("FAIL rst_mid_restart: got %0d bad, %0d pulses, expected 0 1", bad, fd_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_random_frames();
        test_gap();
        test_gap_stop();
        test_continuous_stop();
        test_frame_len1();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
